// File: rtl/demux_pkg.sv
// Shared definitions for the buffered stream demultiplexer.
// Optional feature macro: DEMUX_DROP_CNT_EN (saturating drop counter).
package demux_pkg;

  // Width of the saturating drop counter.
  localparam int DROP_CNT_W = 16;

  // Occupancy counter width: one extra bit so that "full" (count == DEPTH) is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // A select is routable only when it names an existing channel.
  function automatic logic is_valid_sel(input int sel, input int nb);
    return sel < nb;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// One channel buffer: small FIFO with push/full and pop/empty/head.
// The head is zeroed while empty so consumers never see stale data.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  typedef logic [CNT_W-1:0] fifo_cnt_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  fifo_cnt_t         count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_reg == fifo_cnt_t'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + fifo_cnt_t'(1);
        2'b01:   count_reg <= count_reg - fifo_cnt_t'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/stream_demux.sv
// Buffered 1-to-N stream demultiplexer: select decode, ready mux and drop logic,
// with one demux_chan_fifo per channel so stalled consumers do not block each other.
// Optional feature macro: DEMUX_DROP_CNT_EN adds the saturating drop_cnt_o output.
module stream_demux
  import demux_pkg::*;
#(
  parameter  int NB_CHANNELS = 4,
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 2,
  localparam int SEL_W       = $clog2(NB_CHANNELS)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [DATA_W-1:0]                  in_data_i,
  input  logic [SEL_W-1:0]                   in_sel_i,
  output logic [NB_CHANNELS-1:0]             out_valid_o,
  input  logic [NB_CHANNELS-1:0]             out_ready_i,
  output logic [NB_CHANNELS-1:0][DATA_W-1:0] out_data_o,
  output logic                               drop_o
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]              drop_cnt_o
`endif
);

  logic [NB_CHANNELS-1:0] sel_hit;
  logic [NB_CHANNELS-1:0] push_vec;
  logic [NB_CHANNELS-1:0] full_vec;
  logic [NB_CHANNELS-1:0] empty_vec;
  logic                   sel_ok;
  logic                   accept;
  logic                   drop_next;
  logic                   drop_reg;

  // Out-of-range selects are always accepted (and discarded); otherwise ready depends only
  // on the target channel's occupancy, never on out_ready_i.
  assign sel_ok     = is_valid_sel(int'(in_sel_i), NB_CHANNELS);
  assign in_ready_o = sel_ok ? !(|(sel_hit & full_vec)) : 1'b1;
  assign accept     = in_valid_i && in_ready_o;
  assign drop_next  = accept && !sel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NB_CHANNELS; gi++) begin : g_chan
      assign sel_hit[gi]  = (in_sel_i == SEL_W'(gi));
      assign push_vec[gi] = accept && sel_hit[gi];

      demux_chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (push_vec[gi]),
        .push_data (in_data_i),
        .full      (full_vec[gi]),
        .pop       (out_ready_i[gi]),
        .empty     (empty_vec[gi]),
        .head      (out_data_o[gi])
      );

      assign out_valid_o[gi] = !empty_vec[gi];
    end
  endgenerate

  // One-cycle drop pulse, registered one cycle after the discarded accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) drop_reg <= 1'b0;
    else          drop_reg <= drop_next;
  end

  assign drop_o = drop_reg;

`ifdef DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  // Saturating count of discarded transactions, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                            drop_cnt_reg <= '0;
    else if (drop_next && drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
  end

  assign drop_cnt_o = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (NB_CHANNELS=3 so one select value is out of range).
// Reference model: one queue per channel, updated from the handshake rules each cycle.
module tb_stream_demux;

  localparam int NB     = 3;
  localparam int DW     = 32;
  localparam int DEPTH  = 2;
  localparam int SEL_W  = 2;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [DW-1:0]             in_data_i;
  logic [SEL_W-1:0]          in_sel_i;
  logic [NB-1:0]             out_valid_o;
  logic [NB-1:0]             out_ready_i;
  logic [NB-1:0][DW-1:0]     out_data_o;
  logic                      drop_o;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]               drop_cnt_o;
`endif

  stream_demux #(
    .NB_CHANNELS (NB),
    .DATA_W      (DW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_sel_i    (in_sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .drop_o      (drop_o)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef logic [DW-1:0] word_q_t[$];
  word_q_t     q_model [NB];
  logic        drop_exp;
  int unsigned drop_cnt_exp;
  int          tests;
  int          fails;
  bit          verbose;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, compare #1 later, then advance the model
  // to what the coming rising edge should do.
  task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic [DW-1:0] d,
                      input logic [NB-1:0] rdy, output logic acc);
    logic exp_ready;
    logic in_range;
    @(negedge clk_i);
    in_valid_i  = v;
    in_sel_i    = s;
    in_data_i   = d;
    out_ready_i = rdy;
    #1;
    in_range = (int'(s) < NB);
    if (!in_range) exp_ready = 1'b1;
    else           exp_ready = (q_model[s].size() < DEPTH);
    check("in_ready", 32'(in_ready_o), 32'(exp_ready));
    for (int c = 0; c < NB; c++) begin
      check($sformatf("out_valid[%0d]", c), 32'(out_valid_o[c]), 32'(q_model[c].size() > 0));
      check($sformatf("out_data[%0d]", c), out_data_o[c],
            (q_model[c].size() > 0) ? q_model[c][0] : 32'h0);
    end
    check("drop_o", 32'(drop_o), 32'(drop_exp));
`ifdef DEMUX_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt_o), drop_cnt_exp);
`endif
    acc = v && exp_ready;
    if (verbose)
      $display("[TB] t=%0t valid=%0b sel=%0d data=%h ready=%b accepted=%0b", $time, v, s, d, rdy, acc);
    for (int c = 0; c < NB; c++)
      if (q_model[c].size() > 0 && rdy[c]) void'(q_model[c].pop_front());
    if (acc && in_range) q_model[s].push_back(d);
    drop_exp = acc && !in_range;
    if (drop_exp && drop_cnt_exp != 32'hFFFF) drop_cnt_exp++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"}, 32'(out_valid_o), 32'h0);
    for (int c = 0; c < NB; c++) check({tag, " out_data"}, out_data_o[c], 32'h0);
    check({tag, " drop_o"}, 32'(drop_o), 32'h0);
    check({tag, " in_ready"}, 32'(in_ready_o), 32'h1);
`ifdef DEMUX_DROP_CNT_EN
    check({tag, " drop_cnt"}, 32'(drop_cnt_o), 32'h0);
`endif
  endtask

  task automatic clear_model();
    for (int c = 0; c < NB; c++) q_model[c].delete();
    drop_exp     = 1'b0;
    drop_cnt_exp = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc;
    logic        pend_v;
    logic [1:0]  pend_s;
    logic [31:0] pend_d;
    int          sent;
    tests = 0; fails = 0; verbose = 1'b1;
    clear_model();
    rst_n_i = 1'b0; in_valid_i = 1'b0; in_sel_i = '0; in_data_i = '0; out_ready_i = '0;

    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // Basic routing with all consumers ready
    for (int c = 0; c < NB; c++) step(1'b1, 2'(c), 32'hA0 + 32'(c), '1, acc);
    step(1'b0, 2'd0, 32'h0, '1, acc);
    step(1'b0, 2'd0, 32'h0, '1, acc);

    // Backpressure on channel 2, channel 1 still flows
    step(1'b1, 2'd2, 32'hB0, 3'b011, acc);
    step(1'b1, 2'd2, 32'hB1, 3'b011, acc);
    step(1'b1, 2'd2, 32'hB2, 3'b011, acc);
    check("bp third stalled", 32'(acc), 32'h0);
    step(1'b1, 2'd1, 32'hC1, 3'b011, acc);
    step(1'b1, 2'd2, 32'hB2, 3'b111, acc);
    check("bp full while popping", 32'(acc), 32'h0);
    step(1'b1, 2'd2, 32'hB2, 3'b111, acc);
    check("bp third enters", 32'(acc), 32'h1);
    repeat (3) step(1'b0, 2'd0, 32'h0, 3'b111, acc);

    // Channel 0 full with a simultaneous pop, then 10 words through its wrapping pointers
    step(1'b1, 2'd0, 32'hD0, 3'b110, acc);
    step(1'b1, 2'd0, 32'hD1, 3'b110, acc);
    step(1'b1, 2'd0, 32'hD2, 3'b111, acc);
    check("full push refused", 32'(acc), 32'h0);
    step(1'b1, 2'd0, 32'hD2, 3'b111, acc);
    check("push accepted next", 32'(acc), 32'h1);
    sent = 0;
    for (int i = 0; i < 100 && sent < 10; i++) begin
      step(1'b1, 2'd0, 32'hE0 + 32'(sent), {2'b11, 1'($urandom_range(0, 1))}, acc);
      if (acc) sent++;
    end
    check("wrap words sent", 32'(sent), 32'd10);
    repeat (4) step(1'b0, 2'd0, 32'h0, 3'b111, acc);

    // Out-of-range select
    step(1'b1, 2'd3, 32'hDEAD, 3'b111, acc);
    check("oob accepted", 32'(acc), 32'h1);
    step(1'b0, 2'd0, 32'h0, 3'b111, acc);
    step(1'b0, 2'd0, 32'h0, 3'b111, acc);

    // Randomized traffic, each transaction held until accepted
    verbose = 1'b0;
    pend_v = 1'b0; pend_s = '0; pend_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend_v = 1'b1;
        pend_s = 2'($urandom_range(0, 3));
        pend_d = $urandom;
      end
      step(pend_v, pend_s, pend_d, 3'($urandom), acc);
      if (acc) pend_v = 1'b0;
    end
    verbose = 1'b1;

    // Reset mid-stream while channels 1 and 2 hold data
    step(1'b1, 2'd1, 32'hF1, 3'b000, acc);
    step(1'b1, 2'd2, 32'hF2, 3'b000, acc);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("pre-reset ch1 valid", 32'(out_valid_o[1]), 32'h1);
    rst_n_i = 1'b0;
    #1;
    check_all_zero("mid reset");
    clear_model();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) step(1'b0, 2'd0, 32'h0, 3'b000, acc);

`ifdef DEMUX_DROP_CNT_EN
    // Counter saturation
    verbose = 1'b0;
    for (int i = 0; i < 65537; i++) step(1'b1, 2'd3, 32'(i), 3'b111, acc);
    verbose = 1'b1;
    step(1'b0, 2'd0, 32'h0, 3'b111, acc);
    check("drop_cnt saturated", 32'(drop_cnt_o), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
